// File: rtl/ddr4_cmd_pkg.sv
// Shared command encodings, issuer FSM states and default DDR4 timing constants.
package ddr4_cmd_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_TRP,
        S_ACT,
        S_TRCD,
        S_RDWR,
        S_PREA,
        S_TRPA,
        S_REF,
        S_TRFC
    } state_t;

    // Control-pin view of one command; rcw is {RAS_n, CAS_n, WE_n} on A16..A14, ap is A10.
    typedef struct packed {
        logic       cs_n;
        logic       act_n;
        logic [2:0] rcw;
        logic       ap;
    } cmd_ctl_t;

    localparam cmd_ctl_t CMD_NOP  = '{cs_n: 1'b1, act_n: 1'b1, rcw: 3'b111, ap: 1'b0};
    localparam cmd_ctl_t CMD_ACT  = '{cs_n: 1'b0, act_n: 1'b0, rcw: 3'b000, ap: 1'b0};
    localparam cmd_ctl_t CMD_RD   = '{cs_n: 1'b0, act_n: 1'b1, rcw: 3'b101, ap: 1'b0};
    localparam cmd_ctl_t CMD_WR   = '{cs_n: 1'b0, act_n: 1'b1, rcw: 3'b100, ap: 1'b0};
    localparam cmd_ctl_t CMD_PRE  = '{cs_n: 1'b0, act_n: 1'b1, rcw: 3'b010, ap: 1'b0};
    localparam cmd_ctl_t CMD_PREA = '{cs_n: 1'b0, act_n: 1'b1, rcw: 3'b010, ap: 1'b1};
    localparam cmd_ctl_t CMD_REF  = '{cs_n: 1'b0, act_n: 1'b1, rcw: 3'b001, ap: 1'b0};

    localparam int unsigned A_RAS_BIT = 16;
    localparam int unsigned A_AP_BIT  = 10;

    localparam int unsigned DEF_T_RP   = 4;
    localparam int unsigned DEF_T_RCD  = 4;
    localparam int unsigned DEF_T_CCD  = 4;
    localparam int unsigned DEF_T_REFI = 7800;
    localparam int unsigned DEF_T_RFC  = 64;

    // Bits needed to hold any value below max_val (minimum 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cmd_timer.sv
// Loadable down-counter used for the fixed DRAM wait states; zero_c flags an expired wait.
module cmd_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/ddr4_cmd_issuer.sv
// Single-row DDR4 command issuer: turns read/write requests into ACT/PRE/RD/WR
// sequences and interleaves periodic refresh, one registered command per clock.
module ddr4_cmd_issuer
    import ddr4_cmd_pkg::*;
#(
    parameter int unsigned BGWIDTH   = 2,
    parameter int unsigned BAWIDTH   = 2,
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned COLWIDTH  = 10,
    parameter int unsigned T_RP      = DEF_T_RP,
    parameter int unsigned T_RCD     = DEF_T_RCD,
    parameter int unsigned T_CCD     = DEF_T_CCD,
    parameter int unsigned T_REFI    = DEF_T_REFI,
    parameter int unsigned T_RFC     = DEF_T_RFC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 cs_n,
    output logic                 cke,
    output logic                 cmd_rd,
    output logic                 cmd_wr,
    output logic                 busy
);

    localparam int unsigned TMR_W = cnt_width(max3(T_RP, T_RCD, T_RFC));
    localparam int unsigned CCD_W = cnt_width(T_CCD);
    localparam int unsigned REF_W = cnt_width(T_REFI);

    // Wait states last T_x-1 cycles; the timer holds T_x-2 on entry and exits at zero.
    localparam logic [TMR_W-1:0] LD_RP  = TMR_W'((T_RP  > 1) ? T_RP  - 2 : 0);
    localparam logic [TMR_W-1:0] LD_RCD = TMR_W'((T_RCD > 1) ? T_RCD - 2 : 0);
    localparam logic [TMR_W-1:0] LD_RFC = TMR_W'((T_RFC > 1) ? T_RFC - 2 : 0);
    localparam logic [CCD_W-1:0] LD_CCD = CCD_W'((T_CCD > 0) ? T_CCD - 1 : 0);
    localparam logic [REF_W-1:0] REF_TC = REF_W'((T_REFI > 0) ? T_REFI - 1 : 0);
    localparam logic [ADDRWIDTH-1:0] A_NOP = {3'b111, {(ADDRWIDTH - 3){1'b0}}};

    state_t state, state_nxt;

    logic                 open_q, open_nxt;
    logic [BGWIDTH-1:0]   open_bg, open_bg_nxt;
    logic [BAWIDTH-1:0]   open_ba, open_ba_nxt;
    logic [ADDRWIDTH-1:0] open_row, open_row_nxt;

    logic                 cap_we, cap_we_nxt;
    logic [BGWIDTH-1:0]   cap_bg, cap_bg_nxt;
    logic [BAWIDTH-1:0]   cap_ba, cap_ba_nxt;
    logic [ADDRWIDTH-1:0] cap_row, cap_row_nxt;
    logic [COLWIDTH-1:0]  cap_col, cap_col_nxt;

    logic                 ref_pending, ref_pend_nxt, ref_tc;
    logic [REF_W-1:0]     ref_cnt, ref_cnt_nxt;
    logic [CCD_W-1:0]     ccd_cnt, ccd_nxt;

    cmd_ctl_t             ctl_nxt;
    logic                 col_en;
    logic [ADDRWIDTH-1:0] a_nxt;
    logic [BGWIDTH-1:0]   bg_nxt;
    logic [BAWIDTH-1:0]   ba_nxt;
    logic                 rd_nxt, wr_nxt, ready_nxt, busy_nxt;
    logic                 hit;

    logic                 tmr_load, tmr_zero;
    logic [TMR_W-1:0]     tmr_val;

    cmd_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero_c   (tmr_zero)
    );

    assign hit = open_q && (req_bg == open_bg) && (req_ba == open_ba) && (req_row == open_row);

    // Next-state, bookkeeping and next command selection.
    always_comb begin
        state_nxt    = state;
        open_nxt     = open_q;
        open_bg_nxt  = open_bg;
        open_ba_nxt  = open_ba;
        open_row_nxt = open_row;
        cap_we_nxt   = cap_we;
        cap_bg_nxt   = cap_bg;
        cap_ba_nxt   = cap_ba;
        cap_row_nxt  = cap_row;
        cap_col_nxt  = cap_col;
        ctl_nxt      = CMD_NOP;
        col_en       = 1'b0;
        bg_nxt       = '0;
        ba_nxt       = '0;
        rd_nxt       = 1'b0;
        wr_nxt       = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        a_nxt        = '0;

        ref_tc       = (ref_cnt == REF_TC);
        ref_cnt_nxt  = ref_tc ? '0 : ref_cnt + REF_W'(1);
        ref_pend_nxt = ref_pending | ref_tc;
        ccd_nxt      = (ccd_cnt != '0) ? ccd_cnt - CCD_W'(1) : ccd_cnt;

        case (state)
            S_IDLE: begin
                if (ref_pending) begin
                    state_nxt = open_q ? S_PREA : S_REF;
                end else if (req_valid && req_ready) begin
                    cap_we_nxt  = req_we;
                    cap_bg_nxt  = req_bg;
                    cap_ba_nxt  = req_ba;
                    cap_row_nxt = req_row;
                    cap_col_nxt = req_col;
                    if (hit)          state_nxt = S_RDWR;
                    else if (!open_q) state_nxt = S_ACT;
                    else              state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                ctl_nxt  = CMD_PRE;
                bg_nxt   = open_bg;
                ba_nxt   = open_ba;
                open_nxt = 1'b0;
                tmr_load = 1'b1;
                tmr_val  = LD_RP;
                state_nxt = (T_RP > 1) ? S_TRP : S_ACT;
            end
            S_TRP: begin
                if (tmr_zero) state_nxt = S_ACT;
            end
            S_ACT: begin
                ctl_nxt      = CMD_ACT;
                bg_nxt       = cap_bg;
                ba_nxt       = cap_ba;
                open_nxt     = 1'b1;
                open_bg_nxt  = cap_bg;
                open_ba_nxt  = cap_ba;
                open_row_nxt = cap_row;
                tmr_load     = 1'b1;
                tmr_val      = LD_RCD;
                state_nxt    = (T_RCD > 1) ? S_TRCD : S_RDWR;
            end
            S_TRCD: begin
                if (tmr_zero) state_nxt = S_RDWR;
            end
            S_RDWR: begin
                ctl_nxt   = cap_we ? CMD_WR : CMD_RD;
                col_en    = 1'b1;
                bg_nxt    = cap_bg;
                ba_nxt    = cap_ba;
                rd_nxt    = !cap_we;
                wr_nxt    = cap_we;
                ccd_nxt   = LD_CCD;
                state_nxt = S_IDLE;
            end
            S_PREA: begin
                ctl_nxt   = CMD_PREA;
                open_nxt  = 1'b0;
                tmr_load  = 1'b1;
                tmr_val   = LD_RP;
                state_nxt = (T_RP > 1) ? S_TRPA : S_REF;
            end
            S_TRPA: begin
                if (tmr_zero) state_nxt = S_REF;
            end
            S_REF: begin
                // A terminal count landing on this cycle starts the next interval's pending flag.
                ctl_nxt      = CMD_REF;
                ref_pend_nxt = ref_tc;
                tmr_load     = 1'b1;
                tmr_val      = LD_RFC;
                state_nxt    = (T_RFC > 1) ? S_TRFC : S_IDLE;
            end
            S_TRFC: begin
                if (tmr_zero) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (!ctl_nxt.act_n) begin
            a_nxt = cap_row;
        end else begin
            a_nxt[A_RAS_BIT -: 3] = ctl_nxt.rcw;
            a_nxt[A_AP_BIT]       = ctl_nxt.ap;
            if (col_en) a_nxt[COLWIDTH-1:0] = cap_col;
        end

        ready_nxt = (state_nxt == S_IDLE) && !ref_pend_nxt && (ccd_nxt == '0);
        busy_nxt  = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            open_q      <= 1'b0;
            open_bg     <= '0;
            open_ba     <= '0;
            open_row    <= '0;
            cap_we      <= 1'b0;
            cap_bg      <= '0;
            cap_ba      <= '0;
            cap_row     <= '0;
            cap_col     <= '0;
            ref_pending <= 1'b0;
            ref_cnt     <= '0;
            ccd_cnt     <= '0;
            cs_n        <= 1'b1;
            act_n       <= 1'b1;
            A           <= A_NOP;
            bg          <= '0;
            ba          <= '0;
            cke         <= 1'b0;
            req_ready   <= 1'b0;
            cmd_rd      <= 1'b0;
            cmd_wr      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            open_q      <= open_nxt;
            open_bg     <= open_bg_nxt;
            open_ba     <= open_ba_nxt;
            open_row    <= open_row_nxt;
            cap_we      <= cap_we_nxt;
            cap_bg      <= cap_bg_nxt;
            cap_ba      <= cap_ba_nxt;
            cap_row     <= cap_row_nxt;
            cap_col     <= cap_col_nxt;
            ref_pending <= ref_pend_nxt;
            ref_cnt     <= ref_cnt_nxt;
            ccd_cnt     <= ccd_nxt;
            cs_n        <= ctl_nxt.cs_n;
            act_n       <= ctl_nxt.act_n;
            A           <= a_nxt;
            bg          <= bg_nxt;
            ba          <= ba_nxt;
            cke         <= 1'b1;
            req_ready   <= ready_nxt;
            cmd_rd      <= rd_nxt;
            cmd_wr      <= wr_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// Directed bench for ddr4_cmd_issuer: closed/hit/miss accesses, refresh, CCD spacing, mid-sequence reset.
module tb_ddr4_cmd_issuer;

    localparam int unsigned TRFC  = 16;
    localparam int unsigned TCCD  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_bg;
    logic [1:0]  req_ba;
    logic [16:0] req_row;
    logic [9:0]  req_col;
    logic        act_n;
    logic [16:0] A;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic        cs_n;
    logic        cke;
    logic        cmd_rd;
    logic        cmd_wr;
    logic        busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef enum int {K_NOP, K_ACT, K_RD, K_WR, K_PRE, K_PREA, K_REF, K_BAD} kind_t;

    ddr4_cmd_issuer #(
        .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17), .COLWIDTH(10),
        .T_RP(4), .T_RCD(4), .T_CCD(TCCD), .T_REFI(50), .T_RFC(TRFC)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
        .req_col(req_col), .act_n(act_n), .A(A), .bg(bg), .ba(ba), .cs_n(cs_n),
        .cke(cke), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic kind_t decode();
        logic [2:0] rcw;
        rcw = A[16:14];
        if (cs_n === 1'b1) begin
            if (act_n === 1'b1 && rcw === 3'b111) return K_NOP;
            return K_BAD;
        end
        if (act_n === 1'b0) return K_ACT;
        case (rcw)
            3'b101:  if (A[10] === 1'b0) return K_RD; else return K_BAD;
            3'b100:  if (A[10] === 1'b0) return K_WR; else return K_BAD;
            3'b010:  if (A[10] === 1'b1) return K_PREA; else return K_PRE;
            3'b001:  return K_REF;
            default: return K_BAD;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Offer one request and return just after the handshake edge.
    task automatic offer(input logic we, input logic [1:0] b_g, input logic [1:0] b_a,
                         input logic [16:0] row, input logic [9:0] col, output bit ok);
        int n;
        req_we = we; req_bg = b_g; req_ba = b_a; req_row = row; req_col = col;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        ok = (req_ready === 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_bg = '0; req_ba = '0; req_row = '0; req_col = '0;
        tick();
        tick();
        vec_cnt++;
        if ({cs_n, act_n, A, bg, ba} !== {1'b1, 1'b1, 17'h1C000, 2'd0, 2'd0}) begin
            err_cnt++;
            $display("FAIL reset_bus: got cs_n=%b act_n=%b A=%h bg=%0d ba=%0d, expected 1 1 1c000 0 0",
                     cs_n, act_n, A, bg, ba);
        end
        vec_cnt++;
        if ({cke, req_ready, cmd_rd, cmd_wr, busy} !== 5'b00000) begin
            err_cnt++;
            $display("FAIL reset_status: got cke/ready/rd/wr/busy=%b expected 00000",
                     {cke, req_ready, cmd_rd, cmd_wr, busy});
        end
        reset = 1'b0;
        tick();
        vec_cnt++;
        if (cke !== 1'b1) begin
            err_cnt++;
            $display("FAIL cke_after_reset: got %b expected 1", cke);
        end
        vec_cnt++;
        if ({req_ready, busy} !== 2'b10) begin
            err_cnt++;
            $display("FAIL idle_after_reset: got ready/busy=%b expected 10", {req_ready, busy});
        end
    endtask

    task automatic test_closed_read();
        bit ok;
        int bad;
        do_reset();
        offer(1'b0, 2'd1, 2'd2, 17'h1234, 10'h005, ok);
        vec_cnt++;
        if (ok !== 1'b1) begin err_cnt++; $display("FAIL closed_handshake: got timeout expected accept"); end
        tick();
        vec_cnt++;
        if (decode() !== K_ACT || {bg, ba, A} !== {2'd1, 2'd2, 17'h1234}) begin
            err_cnt++;
            $display("FAIL closed_act: got kind=%0d bg=%0d ba=%0d A=%h expected ACT 1 2 01234",
                     decode(), bg, ba, A);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (decode() !== K_NOP) bad++; end
        vec_cnt++;
        if (bad !== 0) begin err_cnt++; $display("FAIL closed_trcd_nops: got %0d non-NOP expected 0", bad); end
        tick();
        vec_cnt++;
        if (decode() !== K_RD || A[9:0] !== 10'h005 || {bg, ba} !== {2'd1, 2'd2}) begin
            err_cnt++;
            $display("FAIL closed_rd: got kind=%0d col=%h bg=%0d ba=%0d expected RD 005 1 2",
                     decode(), A[9:0], bg, ba);
        end
        vec_cnt++;
        if ({cmd_rd, cmd_wr} !== 2'b10) begin
            err_cnt++;
            $display("FAIL closed_rd_pulse: got rd/wr=%b expected 10", {cmd_rd, cmd_wr});
        end
        tick();
        vec_cnt++;
        if ({cmd_rd, cmd_wr} !== 2'b00) begin
            err_cnt++;
            $display("FAIL closed_rd_pulse_end: got rd/wr=%b expected 00", {cmd_rd, cmd_wr});
        end
    endtask

    task automatic test_hit_write();
        bit ok;
        offer(1'b1, 2'd1, 2'd2, 17'h1234, 10'h010, ok);
        vec_cnt++;
        if (ok !== 1'b1 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL hit_handshake: got ok=%b busy=%b expected 1 1", ok, busy);
        end
        tick();
        vec_cnt++;
        if (decode() !== K_WR || A[9:0] !== 10'h010) begin
            err_cnt++;
            $display("FAIL hit_wr: got kind=%0d col=%h expected WR 010", decode(), A[9:0]);
        end
        vec_cnt++;
        if ({cmd_rd, cmd_wr} !== 2'b01) begin
            err_cnt++;
            $display("FAIL hit_wr_pulse: got rd/wr=%b expected 01", {cmd_rd, cmd_wr});
        end
    endtask

    task automatic test_row_miss();
        bit ok;
        int bad;
        offer(1'b0, 2'd1, 2'd2, 17'h0042, 10'h007, ok);
        vec_cnt++;
        if (ok !== 1'b1) begin err_cnt++; $display("FAIL miss_handshake: got timeout expected accept"); end
        tick();
        vec_cnt++;
        if (decode() !== K_PRE || {bg, ba} !== {2'd1, 2'd2}) begin
            err_cnt++;
            $display("FAIL miss_pre: got kind=%0d bg=%0d ba=%0d expected PRE 1 2", decode(), bg, ba);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (decode() !== K_NOP) bad++; end
        tick();
        vec_cnt++;
        if (decode() !== K_ACT || A !== 17'h0042 || bad !== 0) begin
            err_cnt++;
            $display("FAIL miss_act: got kind=%0d A=%h trp_non_nop=%0d expected ACT 00042 0",
                     decode(), A, bad);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (decode() !== K_NOP) bad++; end
        tick();
        vec_cnt++;
        if (decode() !== K_RD || A[9:0] !== 10'h007 || bad !== 0) begin
            err_cnt++;
            $display("FAIL miss_rd: got kind=%0d col=%h trcd_non_nop=%0d expected RD 007 0",
                     decode(), A[9:0], bad);
        end
    endtask

    task automatic test_refresh();
        int    n;
        int    bad;
        kind_t k;
        logic  hs;
        n = 0;
        k = decode();
        while (k !== K_PREA && n < 60) begin tick(); k = decode(); n++; end
        vec_cnt++;
        if (k !== K_PREA || A[10] !== 1'b1) begin
            err_cnt++;
            $display("FAIL ref_prea: got kind=%0d A10=%b expected PREA 1", k, A[10]);
        end
        req_we = 1'b0; req_bg = 2'd2; req_ba = 2'd1; req_row = 17'h0ABC; req_col = 10'h033;
        req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (decode() !== K_NOP || req_ready !== 1'b0) bad++; end
        tick();
        vec_cnt++;
        if (decode() !== K_REF || bad !== 0) begin
            err_cnt++;
            $display("FAIL ref_cmd: got kind=%0d trp_bad=%0d expected REF 0", decode(), bad);
        end
        n = 0;
        k = K_NOP;
        while (k === K_NOP && n < 80) begin
            hs = req_ready;
            tick();
            if (hs === 1'b1) req_valid = 1'b0;
            n++;
            k = decode();
        end
        vec_cnt++;
        if (k !== K_ACT || A !== 17'h0ABC) begin
            err_cnt++;
            $display("FAIL ref_held_act: got kind=%0d A=%h expected ACT 00abc", k, A);
        end
        vec_cnt++;
        if (n < TRFC || n > TRFC + 3) begin
            err_cnt++;
            $display("FAIL ref_trfc_gap: got %0d cycles REF->ACT expected %0d..%0d", n, TRFC, TRFC + 3);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (decode() !== K_NOP) bad++; end
        tick();
        vec_cnt++;
        if (decode() !== K_RD || A[9:0] !== 10'h033 || bad !== 0) begin
            err_cnt++;
            $display("FAIL ref_held_rd: got kind=%0d col=%h bad=%0d expected RD 033 0",
                     decode(), A[9:0], bad);
        end
    endtask

    task automatic test_back_to_back();
        bit         ok;
        int         pulses;
        int         acts;
        int         last;
        int         min_gap;
        logic [3:0] seq;
        logic       hs;
        do_reset();
        offer(1'b0, 2'd0, 2'd0, 17'h0005, 10'h001, ok);
        req_we = 1'b1; req_col = 10'h002;
        req_valid = 1'b1;
        pulses = 0; acts = 0; last = 0; min_gap = 1000; seq = '0;
        for (int cyc = 0; cyc < 80 && pulses < 4; cyc++) begin
            hs = req_ready;
            tick();
            if (hs === 1'b1) req_we = ~req_we;
            if (decode() === K_ACT) acts++;
            if (cmd_rd === 1'b1 || cmd_wr === 1'b1) begin
                seq[pulses] = cmd_wr;
                if (pulses > 0 && (cyc - last) < min_gap) min_gap = cyc - last;
                last = cyc;
                pulses++;
            end
        end
        req_valid = 1'b0;
        vec_cnt++;
        if (ok !== 1'b1 || pulses !== 4) begin
            err_cnt++;
            $display("FAIL b2b_count: got ok=%b pulses=%0d expected 1 4", ok, pulses);
        end
        vec_cnt++;
        if (seq !== 4'b1010) begin
            err_cnt++;
            $display("FAIL b2b_order: got wr-bits=%b expected 1010", seq);
        end
        vec_cnt++;
        if (min_gap < int'(TCCD)) begin
            err_cnt++;
            $display("FAIL b2b_ccd: got min spacing %0d expected >= %0d", min_gap, TCCD);
        end
        vec_cnt++;
        if (acts !== 1) begin
            err_cnt++;
            $display("FAIL b2b_acts: got %0d ACTs expected 1", acts);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad;
        do_reset();
        offer(1'b0, 2'd3, 2'd1, 17'h0777, 10'h002, ok);
        tick();
        vec_cnt++;
        if (ok !== 1'b1 || decode() !== K_ACT) begin
            err_cnt++;
            $display("FAIL mid_act: got ok=%b kind=%0d expected 1 ACT", ok, decode());
        end
        tick();
        reset = 1'b1;
        tick();
        vec_cnt++;
        if ({cs_n, act_n, A} !== {1'b1, 1'b1, 17'h1C000} || cke !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_reset_out: got cs_n=%b act_n=%b A=%h cke=%b busy=%b expected 1 1 1c000 0 0",
                     cs_n, act_n, A, cke, busy);
        end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cmd_rd !== 1'b0 || cmd_wr !== 1'b0 || decode() !== K_NOP) bad++;
        end
        vec_cnt++;
        if (bad !== 0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_no_replay: got %0d command cycles busy=%b expected 0 0", bad, busy);
        end
    endtask

    initial begin
        test_reset();
        test_closed_read();
        test_hit_write();
        test_row_miss();
        test_refresh();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ddr4_cmd_issuer.md
DDR4_CMD_ISSUER -- requirements
Module: ddr4_cmd_issuer

Interface
REQ-001 SHALL have the following parameters (name, default, meaning):
- BGWIDTH, 2, bankgroup address bits
- BAWIDTH, 2, bank address bits
- ADDRWIDTH, 17, row address / A bus width
- COLWIDTH, 10, column bits
- T_RP, 4, clk cycles from PRE/PREA to the next ACT/REF
- T_RCD, 4, cycles from ACT to RD/WR
- T_CCD, 4, minimum cycles between RD/WR
- T_REFI, 7800, refresh interval
- T_RFC, 64, cycles from REF to the next command
REQ-002 SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock
- reset, in, 1, synchronous, active-high
- req_valid, in, 1, request offered
- req_ready, out, 1, request accepted when valid&ready
- req_we, in, 1, 1 = write, 0 = read
- req_bg, in, BGWIDTH, bankgroup
- req_ba, in, BAWIDTH, bank
- req_row, in, ADDRWIDTH, row
- req_col, in, COLWIDTH, column
- act_n, out, 1, DDR4 activate
- A, out, ADDRWIDTH, address/command bus (A16=RAS_n, A15=CAS_n, A14=WE_n, A10=AP)
- bg, out, BGWIDTH, bankgroup
- ba, out, BAWIDTH, bank
- cs_n, out, 1, chip select
- cke, out, 1, clock enable
- cmd_rd, out, 1, one-cycle pulse with each RD issued
- cmd_wr, out, 1, one-cycle pulse with each WR issued
- busy, out, 1, high whenever the FSM is not in IDLE
REQ-003 SHALL use clk and reset only; clocking and reset are synchronous and active-high.

Function
REQ-004 SHALL register all DRAM outputs and drive at most one command per clk.
REQ-005 SHALL use these encodings; A14..A16 and A10 are listed, all other bits come from the row or column value or are 0:
- NOP: cs_n=1, act_n=1, A16..A14=111
- ACT: cs_n=0, act_n=0, A=row
- RD: act_n=1, A16..A14=101, A10=0, A[COLWIDTH-1:0]=col
- WR: A16..A14=100, A10=0, A[COLWIDTH-1:0]=col
- PRE: A16..A14=010, A10=0
- PREA: A16..A14=010, A10=1
- REF: A16..A14=001, cke=1
REQ-006 SHALL track a single open-row tuple {bg, ba, row} plus an open flag, because the DIMM model keeps one row latch.
REQ-007 SHALL implement states IDLE, PRE, TRP, ACT, TRCD, RDWR, PREA, TRPA, REF, TRFC.
REQ-008 SHALL assert req_ready only in IDLE when no refresh is pending and the T_CCD spacing since the last RD/WR has elapsed; a request is captured on handshake.
REQ-009 SHALL route a captured request as follows:
- hit (open and the tuple matches): RDWR on the next cycle.
- nothing open: ACT -> TRCD (T_RCD-1 NOP cycles) -> RDWR.
- miss: PRE of the old bg/ba -> TRP (T_RP-1 NOPs) -> ACT -> TRCD -> RDWR.
REQ-010 SHALL set the open tuple on ACT and clear the open flag on PRE/PREA.
REQ-011 SHALL drive RD or WR per the captured req_we in RDWR, pulse cmd_rd or cmd_wr in that same cycle, and return to IDLE.
REQ-012 SHALL count T_REFI cycles free-running, set ref_pending at terminal count, and restart the count at 0.
REQ-013 SHALL give refresh priority over a simultaneously valid request in IDLE, handled as follows:
- a row is open: PREA -> TRPA (T_RP-1) -> REF -> TRFC (T_RFC-1) -> IDLE.
- no row is open: REF directly.
- ref_pending clears on REF.
REQ-014 SHALL keep ref_pending set if a further terminal count arrives while it is pending; it never becomes a count.
REQ-015 SHALL drive NOP in every wait state.

Reset
REQ-016 SHALL, while reset=1, force the FSM to IDLE, open=0, ref_pending=0, refresh counter=0, and the T_CCD counter to expired.
REQ-017 SHALL, while reset=1, drive cs_n=1, act_n=1, A={3'b111, 0}, bg=0, ba=0, cke=0, req_ready=0, cmd_rd=0, cmd_wr=0, busy=0.
REQ-018 SHALL set cke=1 from the first cycle after reset deasserts.
REQ-019 SHALL abandon any in-flight request when reset asserts mid-sequence; the abandoned request is not replayed.

Structure
REQ-020 SHALL place the command encodings, the state enum and the default timing constants in shared package ddr4_cmd_pkg.
REQ-021 SHALL instantiate one loadable down-counter sub-module, cmd_timer, for the TRP/TRCD/TRPA/TRFC waits.

Verification
REQ-022 Read to a closed bank: bg=1, ba=2, row=0x1234, col=0x05 -> ACT (A=0x1234) at t, RD at t+4 (A[9:0]=0x005), cmd_rd pulses at t+4.
REQ-023 Row hit write: second request with the same tuple, col=0x10 -> WR exactly 1 cycle after the handshake, with no ACT.
REQ-024 Row miss: open row 0x1234, then a request to row 0x0042 -> PRE, 3 NOPs, ACT with A=0x0042, 3 NOPs, RD.
REQ-025 Refresh with T_REFI=50 and a row open -> PREA (A10=1), T_RP wait, REF, req_ready low for T_RFC cycles; a valid request is held and then serviced via ACT.
REQ-026 Back-to-back hits -> RD/WR spacing of at least T_CCD=4 cycles.
REQ-027 Reset asserted during TRCD -> NOP outputs next cycle, cke=0, and no RD is issued afterward.
